// File: rtl/stage_4_mem_wb_if.sv
// Data-memory bus between the memory/write-back stage and the data memory.
// The stage is the master: it raises a request and holds the access
// attributes until the memory acknowledges.
interface stage_4_mem_wb_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/stage_4_mem_wb.sv
// Memory-access and write-back stage.
// Accepts one op from execute, runs the data-memory handshake for loads and
// stores, formats load data and presents the write-back value with a
// one-cycle valid strobe. Misaligned accesses and bus timeouts abort the op.
// Memory results are registered on the acknowledge edge so that a load's
// write-back appears during the WB cycle; non-memory ops retire on the edge
// that leaves WB, which keeps both paths at their documented latencies.
module stage_4_mem_wb #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      store_data,
    input  logic [31:0]      pc_plus4,
    input  logic             memread,
    input  logic             memwrite,
    input  logic             memtoreg,
    input  logic             link,
    input  logic             mem_signed,
    input  logic [1:0]       mem_length,
    stage_4_mem_wb_if.master mem,
    output logic [31:0]      wb_data,
    output logic             wb_valid,
    output logic             done,
    output logic             busy,
    output logic             misalign,
    output logic             bus_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2
    } state_t;

    // Counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on the
    // cycle that would make it TIMEOUT_CYCLES.
    localparam int                 CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit                 TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]   CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    // Byte enables for an access of the given size at the given byte offset.
    function automatic logic [3:0] be_f(input logic [1:0] len, input logic [1:0] off);
        logic [3:0] be;
        case (len)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the access may hit.
    function automatic logic [31:0] wdata_f(input logic [1:0] len, input logic [31:0] sd);
        logic [31:0] wd;
        case (len)
            2'b00:   wd = {4{sd[7:0]}};
            2'b01:   wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] load_f(input logic [1:0] len, input logic sgn,
                                           input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        case (off)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (len)
            2'b00:   v = {{24{sgn & b[7]}}, b};
            2'b01:   v = {{16{sgn & h[15]}}, h};
            default: v = rd;
        endcase
        return v;
    endfunction

    // Write-back source priority: link, then load data, then ALU result.
    function automatic logic [31:0] wb_sel_f(input logic lnk, input logic m2r,
                                             input logic [31:0] pc4, input logic [31:0] ld,
                                             input logic [31:0] alu);
        logic [31:0] v;
        if (lnk) begin
            v = pc4;
        end else if (m2r) begin
            v = ld;
        end else begin
            v = alu;
        end
        return v;
    endfunction

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [31:0]      alu_q,       alu_d;
    logic [31:0]      pc4_q,       pc4_d;
    logic             memop_q,     memop_d;
    logic             store_q,     store_d;
    logic             m2r_q,       m2r_d;
    logic             link_q,      link_d;
    logic             sgn_q,       sgn_d;
    logic [1:0]       len_q,       len_d;
    logic             mem_req_q,   mem_req_d;
    logic             mem_we_q,    mem_we_d;
    logic [31:0]      mem_addr_q,  mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q,    mem_be_d;
    logic [31:0]      wb_data_q,   wb_data_d;
    logic             wb_valid_q,  wb_valid_d;
    logic             done_q,      done_d;
    logic             busy_q,      busy_d;
    logic             misalign_q,  misalign_d;
    logic             bus_err_q,   bus_err_d;

    logic             is_mem_s;
    logic             is_mis_s;

    // Classify the incoming op: memory access, and whether it is misaligned.
    always_comb begin
        is_mem_s = memread | memwrite;
        if (mem_length == 2'b00) begin
            is_mis_s = 1'b0;
        end else if (mem_length == 2'b01) begin
            is_mis_s = alu_result[0];
        end else begin
            is_mis_s = (alu_result[1:0] != 2'b00);
        end
    end

    // Next-state, latched-op and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_d       = alu_q;
        pc4_d       = pc4_q;
        memop_d     = memop_q;
        store_d     = store_q;
        m2r_d       = m2r_q;
        link_d      = link_q;
        sgn_d       = sgn_q;
        len_d       = len_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wb_data_d   = wb_data_q;
        wb_valid_d  = 1'b0;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    alu_d   = alu_result;
                    pc4_d   = pc_plus4;
                    memop_d = is_mem_s;
                    store_d = memwrite;
                    m2r_d   = memtoreg;
                    link_d  = link;
                    sgn_d   = mem_signed;
                    len_d   = mem_length;
                    if (is_mem_s && is_mis_s) begin
                        misalign_d = 1'b1;
                        done_d     = 1'b1;
                    end else if (is_mem_s) begin
                        state_d     = S_ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = memwrite;
                        mem_addr_d  = {alu_result[31:2], 2'b00};
                        mem_wdata_d = wdata_f(mem_length, store_data);
                        mem_be_d    = be_f(mem_length, alu_result[1:0]);
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (mem.mem_ack) begin
                    state_d   = S_WB;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!store_q) begin
                        wb_data_d  = wb_sel_f(link_q, m2r_q, pc4_q,
                                              load_f(len_q, sgn_q, alu_q[1:0], mem.mem_rdata),
                                              alu_q);
                        wb_valid_d = 1'b1;
                    end else begin
                        wb_valid_d = 1'b0;
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    done_d    = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                if (!memop_q) begin
                    wb_data_d  = wb_sel_f(link_q, m2r_q, pc4_q, 32'h0000_0000, alu_q);
                    wb_valid_d = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_q       <= 32'h0000_0000;
            pc4_q       <= 32'h0000_0000;
            memop_q     <= 1'b0;
            store_q     <= 1'b0;
            m2r_q       <= 1'b0;
            link_q      <= 1'b0;
            sgn_q       <= 1'b0;
            len_q       <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            wb_data_q   <= 32'h0000_0000;
            wb_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_q       <= alu_d;
            pc4_q       <= pc4_d;
            memop_q     <= memop_d;
            store_q     <= store_d;
            m2r_q       <= m2r_d;
            link_q      <= link_d;
            sgn_q       <= sgn_d;
            len_q       <= len_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wb_data_q   <= wb_data_d;
            wb_valid_q  <= wb_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;
    assign wb_data       = wb_data_q;
    assign wb_valid      = wb_valid_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign misalign      = misalign_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_stage_4_mem_wb.sv
// Bench for stage_4_mem_wb: directed scenarios plus random ops, each checked
// cycle by cycle against a reference model built from plain arithmetic.
module tb_stage_4_mem_wb;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] alu_result, store_data, pc_plus4;
    logic        memread, memwrite, memtoreg, link, mem_signed;
    logic [1:0]  mem_length;
    logic [31:0] wb_data;
    logic        wb_valid, done, busy, misalign, bus_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] last_wb;

    stage_4_mem_wb_if mem_bus ();

    stage_4_mem_wb #(.TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .alu_result (alu_result),
        .store_data (store_data),
        .pc_plus4   (pc_plus4),
        .memread    (memread),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .link       (link),
        .mem_signed (mem_signed),
        .mem_length (mem_length),
        .mem        (mem_bus),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid),
        .done       (done),
        .busy       (busy),
        .misalign   (misalign),
        .bus_err    (bus_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic scramble();
        alu_result = $urandom;
        store_data = $urandom;
        pc_plus4   = $urandom;
        memread    = 1'($urandom);
        memwrite   = 1'($urandom);
        memtoreg   = 1'($urandom);
        link       = 1'($urandom);
        mem_signed = 1'($urandom);
        mem_length = 2'($urandom);
    endtask

    // Issue one op and follow it to retirement; waits = ack delay in cycles
    // (waits >= TO means no ack, so the access must time out).
    task automatic run_op(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                          input logic rd, input logic wr, input logic m2r, input logic lnk,
                          input logic sgn, input logic [1:0] len, input int waits,
                          input logic [31:0] rdata);
        logic        memop, mis, acked;
        int          nbytes, lane;
        logic [31:0] mask, exp_be, exp_wd, load_v, exp_wb;

        nbytes = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        lane   = (int'(alu[1:0]) / nbytes) * nbytes;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        memop  = rd | wr;
        mis    = memop && ((int'(alu[1:0]) % nbytes) != 0);
        exp_be = ((32'd1 << nbytes) - 32'd1) << lane;
        exp_wd = (sd & mask) * ((nbytes == 1) ? 32'h0101_0101 : (nbytes == 2) ? 32'h0001_0001 : 32'h1);
        load_v = (rdata >> (8 * lane)) & mask;
        if (sgn && nbytes < 4 && load_v[8 * nbytes - 1]) load_v = load_v | ~mask;
        exp_wb = lnk ? pc4 : (m2r ? load_v : alu);

        start = 1'b1; alu_result = alu; store_data = sd; pc_plus4 = pc4;
        memread = rd; memwrite = wr; memtoreg = m2r; link = lnk; mem_signed = sgn; mem_length = len;
        step();
        start = 1'b0;
        scramble();

        if (mis) begin
            chk("misalign", 32'(misalign), 32'(1'b1));
            chk("mis_done", 32'(done), 32'(1'b1));
            chk("mis_req", 32'(mem_bus.mem_req), 32'(1'b0));
            chk("mis_busy", 32'(busy), 32'(1'b0));
            chk("mis_wbv", 32'(wb_valid), 32'(1'b0));
            step();
            chk("mis_pulse", 32'(misalign), 32'(1'b0));
            chk("mis_req2", 32'(mem_bus.mem_req), 32'(1'b0));
        end else if (!memop) begin
            chk("alu_busy", 32'(busy), 32'(1'b1));
            chk("alu_req", 32'(mem_bus.mem_req), 32'(1'b0));
            chk("alu_wbv0", 32'(wb_valid), 32'(1'b0));
            step();
            chk("alu_wbv", 32'(wb_valid), 32'(1'b1));
            chk("alu_done", 32'(done), 32'(1'b1));
            chk("alu_wbd", wb_data, exp_wb);
            chk("alu_idle", 32'(busy), 32'(1'b0));
            last_wb = exp_wb;
        end else begin
            acked = 1'b0;
            for (int i = 0; i < TO && !acked; i++) begin
                chk("acc_req", 32'(mem_bus.mem_req), 32'(1'b1));
                chk("acc_we", 32'(mem_bus.mem_we), 32'(wr));
                chk("acc_addr", mem_bus.mem_addr, alu & 32'hFFFF_FFFC);
                chk("acc_be", 32'(mem_bus.mem_be), exp_be);
                chk("acc_wdata", mem_bus.mem_wdata, exp_wd);
                chk("acc_busy", 32'(busy), 32'(1'b1));
                chk("acc_wbv", 32'(wb_valid), 32'(1'b0));
                if (i == waits) begin
                    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = rdata; acked = 1'b1;
                end else begin
                    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = $urandom;
                end
                step();
                mem_bus.mem_ack = 1'b0;
                mem_bus.mem_rdata = $urandom;
            end
            if (acked) begin
                chk("wb_req", 32'(mem_bus.mem_req), 32'(1'b0));
                chk("wb_done", 32'(done), 32'(1'b1));
                chk("wb_valid", 32'(wb_valid), 32'(!wr));
                chk("wb_data", wb_data, wr ? last_wb : exp_wb);
                chk("wb_berr", 32'(bus_err), 32'(1'b0));
                if (!wr) last_wb = exp_wb;
                step();
                chk("ret_busy", 32'(busy), 32'(1'b0));
                chk("ret_done", 32'(done), 32'(1'b0));
                chk("ret_wbv", 32'(wb_valid), 32'(1'b0));
            end else begin
                chk("to_req", 32'(mem_bus.mem_req), 32'(1'b0));
                chk("to_berr", 32'(bus_err), 32'(1'b1));
                chk("to_done", 32'(done), 32'(1'b1));
                chk("to_wbv", 32'(wb_valid), 32'(1'b0));
                chk("to_busy", 32'(busy), 32'(1'b0));
                mem_bus.mem_ack = 1'b1;
                mem_bus.mem_rdata = $urandom;
                step();
                mem_bus.mem_ack = 1'b0;
                chk("late_wbv", 32'(wb_valid), 32'(1'b0));
                chk("late_req", 32'(mem_bus.mem_req), 32'(1'b0));
                chk("late_busy", 32'(busy), 32'(1'b0));
                chk("late_berr", 32'(bus_err), 32'(1'b0));
                chk("late_wbd", wb_data, last_wb);
            end
        end
    endtask

    initial begin
        logic        rd, wr, lnk;
        logic [31:0] a;
        reset = 1'b1;
        start = 1'b0;
        scramble();
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 32'h0000_0000;
        last_wb = 32'h0000_0000;
        step();
        step();
        chk("rst_req", 32'(mem_bus.mem_req), 32'(1'b0));
        chk("rst_we", 32'(mem_bus.mem_we), 32'(1'b0));
        chk("rst_addr", mem_bus.mem_addr, 32'h0000_0000);
        chk("rst_wdata", mem_bus.mem_wdata, 32'h0000_0000);
        chk("rst_be", 32'(mem_bus.mem_be), 32'h0000_0000);
        chk("rst_wbd", wb_data, 32'h0000_0000);
        chk("rst_wbv", 32'(wb_valid), 32'(1'b0));
        chk("rst_done", 32'(done), 32'(1'b0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_mis", 32'(misalign), 32'(1'b0));
        chk("rst_berr", 32'(bus_err), 32'(1'b0));
        reset = 1'b0;

        // ALU op
        run_op(32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 0, 32'h0);
        // signed / unsigned byte load at 0x103 after 3 wait cycles
        run_op(32'h0000_0103, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3, 32'h80FF_FF00);
        run_op(32'h0000_0103, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3, 32'h80FF_FF00);
        // half store at 0x202
        run_op(32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2, 32'h0);
        // misaligned word load, then jal
        run_op(32'h0000_0205, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 0, 32'h0);
        run_op(32'h0000_0000, 32'h0, 32'h0040_0008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 0, 32'h0);
        // zero-wait half load, then timeout with a late ack
        run_op(32'h0000_0302, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 0, 32'h8001_7FFF);
        run_op(32'h0000_0400, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, TO, 32'h0);

        // ack arriving while idle is ignored
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("idle_ack_busy", 32'(busy), 32'(1'b0));
        chk("idle_ack_wbv", 32'(wb_valid), 32'(1'b0));
        chk("idle_ack_req", 32'(mem_bus.mem_req), 32'(1'b0));

        // reset in the middle of an access
        start = 1'b1; alu_result = 32'h0000_0500; memread = 1'b1; memwrite = 1'b0;
        memtoreg = 1'b1; link = 1'b0; mem_length = 2'b10;
        step();
        start = 1'b0;
        step();
        chk("pre_rst_req", 32'(mem_bus.mem_req), 32'(1'b1));
        reset = 1'b1;
        step();
        chk("mid_rst_req", 32'(mem_bus.mem_req), 32'(1'b0));
        chk("mid_rst_busy", 32'(busy), 32'(1'b0));
        chk("mid_rst_wbd", wb_data, 32'h0000_0000);
        last_wb = 32'h0000_0000;
        reset = 1'b0;
        run_op(32'h0000_0777, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 32'h0);

        // random ops
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       begin rd = 1'b0; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            lnk = (!rd && !wr) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op(a, $urandom, $urandom, rd, wr, rd, lnk, 1'($urandom), 2'($urandom),
                   $urandom_range(0, TO + 1), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_4_mem_wb.md
Name: stage_4_mem_wb

Overview:
- Memory-access and write-back stage: the producing end of the `wb_data` path that the decode stage consumes.
- Accepts one operation from the execute stage and runs the data-memory request/acknowledge handshake for loads and stores.
- Formats load data using `mem_length` and `mem_signed`, selects the write-back value, and presents it with a one-cycle valid strobe.
- Also produces the byte-enables for stores and detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in ACCESS waiting for `mem_ack` before the access is aborted. 0 disables the timeout.

Ports:
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  operation valid from execute; accepted only in IDLE
- alu_result  in  32  effective address, or ALU result for non-memory ops
- store_data  in  32  register data to be stored (rt)
- pc_plus4  in  32  return address for link ops
- memread  in  1  op is a load
- memwrite  in  1  op is a store
- memtoreg  in  1  write-back selects load data
- link  in  1  write-back selects `pc_plus4`
- mem_signed  in  1  load sign-extends when 1, zero-extends when 0
- mem_length  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write request
- mem_addr  out  32  word address, `{addr[31:2],2'b00}`
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables, little-endian
- mem_rdata  in  32  read data; sampled when `mem_ack`=1
- mem_ack  in  1  access completes this cycle
- wb_data  out  32  write-back value, held until the next `wb_valid`
- wb_valid  out  1  one-cycle pulse: `wb_data` is new
- done  out  1  one-cycle pulse when any accepted op retires
- busy  out  1  1 in any state other than IDLE
- misalign  out  1  one-cycle pulse: op aborted for misalignment
- bus_err  out  1  one-cycle pulse: op aborted by timeout

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-ACCESS drops `mem_req` at that edge; any later `mem_ack` is ignored.
- States: IDLE, ACCESS, WB.
- IDLE:
  - `start`=1 latches all op inputs.
  - Misaligned case (half with addr[0]=1, or word/11 with addr[1:0]≠0) while `memread`|`memwrite`: go to IDLE, pulse `misalign` and `done` the next cycle. No request is issued and `wb_valid` stays 0.
  - Memory op otherwise: go to ACCESS.
  - Non-memory op: go to WB.
  - `start` while `busy`=1 is ignored; the upstream stage must hold it.
- ACCESS:
  - `mem_req`=1, with `mem_we`/`mem_addr`/`mem_wdata`/`mem_be` stable from the entry cycle until the ack cycle inclusive.
  - `mem_ack`=1: capture `mem_rdata`, deassert `mem_req` at the next edge, go to WB.
  - A zero-wait ack (ack in the first ACCESS cycle) is legal.
  - Timeout counter increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES: drop `mem_req`, pulse `bus_err` and `done`, return to IDLE with no write-back.
  - If ack and timeout coincide, ack wins.
- WB (one cycle):
  - `wb_data` priority: `link` → `pc_plus4`; else `memtoreg` → formatted load data; else `alu_result`.
  - `wb_valid`=1 unless the op is a store; `done`=1 always. Then go to IDLE.
- Byte enables: byte → `4'b0001 << addr[1:0]`; half → `addr[1] ? 1100 : 0011`; word → 1111.
- Store data: byte → `{4{sd[7:0]}}`; half → `{2{sd[15:0]}}`; word → `sd`.
- Load format: select the lane given by `addr[1:0]` (half uses `addr[1]`), then sign- or zero-extend to 32 bits per `mem_signed`.
- Latency:
  - Non-memory op: `start` at cycle t → `wb_valid` at t+2.
  - Memory op: `mem_req` at t+1; ack at cycle t+1+k → `wb_valid` at t+2+k.
- `mem_ack` outside ACCESS is ignored.

Test Plan:
- ALU op, `alu_result`=0x1234, no mem/link → no `mem_req`; `wb_valid` 2 cycles after `start` with `wb_data`=0x00001234.
- Signed byte load at addr 0x103, `mem_rdata`=0x80FF_FF00, ack after 3 wait cycles:
  - During ACCESS: `mem_addr`=0x100 and `mem_be`=1000.
  - Result: `wb_data`=0xFFFFFF80.
  - Repeat with `mem_signed`=0 → 0x00000080.
- Half store at 0x202, `store_data`=0xAAAA_BEEF → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xBEEFBEEF, held until ack; `done` pulses; `wb_valid` stays 0.
- Word load at 0x205 → `misalign` pulse, no `mem_req` ever, `wb_valid`=0. Then a `jal` op with `link`=1, `pc_plus4`=0x0040_0008 → `wb_data`=0x00400008.
- TIMEOUT_CYCLES=4, no ack → `mem_req` drops after 4 cycles, `bus_err` and `done` pulse. A late `mem_ack` is ignored and `wb_valid` stays 0.
- `reset` asserted mid-ACCESS → `mem_req`, `busy` = 0 after the edge. A `start` the cycle after reset is released is accepted normally.
